note_sequencer: RTL and testbench

Step sequencer sitting between the user controls and the tone/envelope datapath of the audio design. It holds a 16-step pattern of note indices, advances through it at a programmable step period, and on every non-rest step drives a new frequency to the tone generator together with a one-cycle start pulse for the envelope monostable. This replaces hand-clocked note changes with a timed, repeatable schedule in the `sys_clk` domain.

---
 rtl/note_sequencer_if.sv | 26 ++
 rtl/note_sequencer.sv | 133 +++++++++++++
 tb/tb_note_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// Control/status bundle between the user-control block and note_sequencer.
// master = controller side, slave = sequencer side.
interface note_sequencer_if #(
   parameter int FREQ_W = 32
);
   logic              run;
   logic [25:0]       step_period;
   logic              wr_en;
   logic [3:0]        wr_addr;
   logic [3:0]        wr_note;
   logic [FREQ_W-1:0] freq;
   logic              note_start;
   logic [3:0]        step_idx;
   logic              playing;
   logic              done;

   modport master (
      output run, step_period, wr_en, wr_addr, wr_note,
      input  freq, note_start, step_idx, playing, done
   );

   modport slave (
      input  run, step_period, wr_en, wr_addr, wr_note,
      output freq, note_start, step_idx, playing, done
   );
endinterface

// File: rtl/note_sequencer.sv
// 16-step note sequencer: plays a pattern of note indices at a programmable step period.
// Define NOTE_SEQUENCER_LOOP_EN to loop the pattern forever; otherwise one pass per run.
module note_sequencer #(
   parameter int SYS_CLK_FREQ = 50_000_000,
   parameter int FREQ_W       = 32
) (
   input  logic             sys_clk,
   input  logic             reset,
   note_sequencer_if.slave  bus
);

   if (SYS_CLK_FREQ <= 0) begin : g_bad_clk
      $error("note_sequencer: SYS_CLK_FREQ must be positive");
   end

   typedef enum logic [1:0] {IDLE, LOAD, FIRE, WAIT} state_t;

   state_t            state;
   logic [3:0]        pattern [16];
   logic [3:0]        cur_note;
   logic [25:0]       count;
   logic [25:0]       eff_period;
   logic [10:0]       note_hz;
   logic [FREQ_W-1:0] freq_q;
   logic              note_start_q;
   logic [3:0]        step_q;
   logic              playing_q;
   logic              done_q;

   assign bus.freq       = freq_q;
   assign bus.note_start = note_start_q;
   assign bus.step_idx   = step_q;
   assign bus.playing    = playing_q;
   assign bus.done       = done_q;

   // FIRE+WAIT+LOAD overhead is 3 cycles, so shorter periods cannot be honoured.
   always_comb begin
      eff_period = (bus.step_period < 26'd3) ? 26'd3 : bus.step_period;
   end

   always_comb begin
      case (cur_note)
         4'd1:    note_hz = 11'd262;
         4'd2:    note_hz = 11'd294;
         4'd3:    note_hz = 11'd330;
         4'd4:    note_hz = 11'd349;
         4'd5:    note_hz = 11'd392;
         4'd6:    note_hz = 11'd440;
         4'd7:    note_hz = 11'd494;
         4'd8:    note_hz = 11'd523;
         4'd9:    note_hz = 11'd587;
         4'd10:   note_hz = 11'd659;
         4'd11:   note_hz = 11'd698;
         4'd12:   note_hz = 11'd784;
         4'd13:   note_hz = 11'd880;
         4'd14:   note_hz = 11'd988;
         4'd15:   note_hz = 11'd1047;
         default: note_hz = 11'd0;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) pattern[i] <= 4'd0;
      end else if (bus.wr_en) begin
         pattern[bus.wr_addr] <= bus.wr_note;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state        <= IDLE;
         count        <= 26'd0;
         cur_note     <= 4'd0;
         freq_q       <= '0;
         note_start_q <= 1'b0;
         step_q       <= 4'd0;
         playing_q    <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         note_start_q <= 1'b0;
         done_q       <= 1'b0;
         case (state)
            IDLE: begin
               step_q <= 4'd0;
               if (bus.run) begin
                  state     <= LOAD;
                  playing_q <= 1'b1;
               end else begin
                  playing_q <= 1'b0;
               end
            end
            LOAD: begin
               // A write landing on the step being fetched wins over the stored entry.
               cur_note <= (bus.wr_en && (bus.wr_addr == step_q)) ? bus.wr_note
                                                                 : pattern[step_q];
               state    <= FIRE;
            end
            FIRE: begin
               if (cur_note != 4'd0) begin
                  freq_q       <= FREQ_W'(note_hz);
                  note_start_q <= 1'b1;
               end
               count <= eff_period - 26'd3;
               state <= WAIT;
            end
            WAIT: begin
               if (count != 26'd0) begin
                  count <= count - 26'd1;
               end else if (!bus.run) begin
                  state     <= IDLE;
                  playing_q <= 1'b0;
                  step_q    <= 4'd0;
               end else if (step_q == 4'd15) begin
                  done_q <= 1'b1;
                  step_q <= 4'd0;
`ifdef NOTE_SEQUENCER_LOOP_EN
                  state  <= LOAD;
`else
                  state     <= IDLE;
                  playing_q <= 1'b0;
`endif
               end else begin
                  step_q <= step_q + 4'd1;
                  state  <= LOAD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: a vector table for the basic play/stop path
// plus hand-written sequences for timing, bypass, end-of-pattern and reset cases.
module tb_note_sequencer;
   localparam int FREQ_W = 32;

   logic sys_clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   note_sequencer_if #(.FREQ_W(FREQ_W)) bus ();

   note_sequencer #(
      .SYS_CLK_FREQ(50_000_000),
      .FREQ_W      (FREQ_W)
   ) dut (
      .sys_clk(sys_clk),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic        run;
      logic [25:0] period;
      logic        wr_en;
      logic [3:0]  wr_addr;
      logic [3:0]  wr_note;
      logic [31:0] e_freq;
      logic        e_start;
      logic [3:0]  e_step;
      logic        e_play;
      logic        e_done;
   } vec_t;

   vec_t vecs[$];

   task automatic tick();
      @(posedge sys_clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic run, input int period, input logic wr_en,
                          input int addr, input int note, input int fr,
                          input logic st, input int stp, input logic pl, input logic dn);
      vec_t v;
      v.run     = run;
      v.period  = 26'(period);
      v.wr_en   = wr_en;
      v.wr_addr = 4'(addr);
      v.wr_note = 4'(note);
      v.e_freq  = 32'(fr);
      v.e_start = st;
      v.e_step  = 4'(stp);
      v.e_play  = pl;
      v.e_done  = dn;
      vecs.push_back(v);
   endtask

   task automatic apply_stimulus(input vec_t v);
      bus.run         = v.run;
      bus.step_period = v.period;
      bus.wr_en       = v.wr_en;
      bus.wr_addr     = v.wr_addr;
      bus.wr_note     = v.wr_note;
   endtask

   task automatic check_output(input vec_t v, input int idx);
      check($sformatf("vec%0d.freq", idx),       bus.freq,                 v.e_freq);
      check($sformatf("vec%0d.note_start", idx), 32'(bus.note_start),      32'(v.e_start));
      check($sformatf("vec%0d.step_idx", idx),   32'(bus.step_idx),        32'(v.e_step));
      check($sformatf("vec%0d.playing", idx),    32'(bus.playing),         32'(v.e_play));
      check($sformatf("vec%0d.done", idx),       32'(bus.done),            32'(v.e_done));
   endtask

   task automatic do_reset();
      reset           = 1'b1;
      bus.run         = 1'b0;
      bus.step_period = 26'd3;
      bus.wr_en       = 1'b0;
      bus.wr_addr     = 4'd0;
      bus.wr_note     = 4'd0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Step i holds note (i % 15) + 1, so every step sounds.
   task automatic write_pattern();
      for (int i = 0; i < 16; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = 4'(i);
         bus.wr_note = 4'((i % 15) + 1);
         tick();
      end
      bus.wr_en = 1'b0;
   endtask

   task automatic wait_event(input bit sel_done, input int budget, input string name,
                             output int at);
      int n;
      n  = 0;
      at = -1;
      while (n < budget && at < 0) begin
         tick();
         n++;
         if ((sel_done ? bus.done : bus.note_start) === 1'b1) at = cyc;
      end
      if (at < 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s timeout actual=none expected=pulse within %0d cycles", name, budget);
      end
   endtask

   initial begin
      int p1, p2, p3, p4, ck, done_at, pulses, bad_play;

      // Reset state
      do_reset();
      check("rst.freq",       bus.freq,            32'd0);
      check("rst.note_start", 32'(bus.note_start), 32'd0);
      check("rst.step_idx",   32'(bus.step_idx),   32'd0);
      check("rst.playing",    32'(bus.playing),    32'd0);
      check("rst.done",       32'(bus.done),       32'd0);

      // All-rest pattern: plays silently
      bus.run = 1'b1;
      bus.step_period = 26'd3;
      pulses = 0;
      bad_play = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.note_start === 1'b1) pulses++;
         if (bus.playing !== 1'b1) bad_play++;
      end
      check("rest.pulses",    32'(pulses),   32'd0);
      check("rest.freq",      bus.freq,      32'd0);
      check("rest.play_lost", 32'(bad_play), 32'd0);

      // Table: 440 then 880 ten cycles apart, run dropped mid-step
      do_reset();
      add_vec(0, 10, 1, 0, 6,  0,   0, 0, 0, 0);
      add_vec(0, 10, 1, 1, 13, 0,   0, 0, 0, 0);
      add_vec(1, 10, 0, 0, 0,  0,   0, 0, 1, 0);
      add_vec(1, 10, 0, 0, 0,  0,   0, 0, 1, 0);
      add_vec(1, 10, 0, 0, 0,  440, 1, 0, 1, 0);
      for (int i = 0; i < 7; i++) add_vec(1, 10, 0, 0, 0, 440, 0, 0, 1, 0);
      add_vec(1, 10, 0, 0, 0,  440, 0, 1, 1, 0);
      add_vec(1, 10, 0, 0, 0,  440, 0, 1, 1, 0);
      add_vec(1, 10, 0, 0, 0,  880, 1, 1, 1, 0);
      for (int i = 0; i < 7; i++) add_vec(0, 10, 0, 0, 0, 880, 0, 1, 1, 0);
      add_vec(0, 10, 0, 0, 0,  880, 0, 0, 0, 0);
      add_vec(0, 10, 0, 0, 0,  880, 0, 0, 0, 0);
      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i]);
         tick();
         check_output(vecs[i], i);
      end

      // Minimum period and a mid-WAIT period change
      do_reset();
      write_pattern();
      bus.step_period = 26'd0;
      bus.run = 1'b1;
      wait_event(1'b0, 20, "minper.p1", p1);
      check("minper.freq1", bus.freq, 32'd262);
      wait_event(1'b0, 20, "minper.p2", p2);
      check("minper.freq2", bus.freq, 32'd294);
      check("minper.gap12", 32'(p2 - p1), 32'd3);
      bus.step_period = 26'd20;
      wait_event(1'b0, 20, "minper.p3", p3);
      check("minper.freq3", bus.freq, 32'd330);
      check("minper.gap23", 32'(p3 - p2), 32'd3);
      wait_event(1'b0, 40, "minper.p4", p4);
      check("minper.freq4", bus.freq, 32'd349);
      check("minper.gap34", 32'(p4 - p3), 32'd20);
      bus.run = 1'b0;

      // Write to the step being loaded bypasses the pattern register
      do_reset();
      bus.step_period = 26'd5;
      bus.run = 1'b1;
      tick();
      check("bypass.playing", 32'(bus.playing), 32'd1);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'd0;
      bus.wr_note = 4'd15;
      tick();
      bus.wr_en = 1'b0;
      tick();
      check("bypass.freq",       bus.freq,            32'd1047);
      check("bypass.note_start", 32'(bus.note_start), 32'd1);
      bus.run = 1'b0;

      // Full pattern at period 5 and end-of-pattern behaviour
      do_reset();
      write_pattern();
      bus.step_period = 26'd5;
      bus.run = 1'b1;
      tick();
      ck = cyc;
      pulses = 0;
      done_at = -1;
      for (int i = 0; i < 100 && done_at < 0; i++) begin
         tick();
         if (bus.note_start === 1'b1) pulses++;
         if (bus.done === 1'b1) done_at = cyc;
      end
      if (done_at < 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL full.done timeout actual=none expected=pulse");
      end
      check("full.pulses",   32'(pulses),       32'd16);
      check("full.done_at",  32'(done_at - ck), 32'd80);
      check("full.step",     32'(bus.step_idx), 32'd0);
      check("full.lastfreq", bus.freq,          32'd262);
`ifdef NOTE_SEQUENCER_LOOP_EN
      check("full.playing_end", 32'(bus.playing), 32'd1);
`else
      check("full.playing_end", 32'(bus.playing), 32'd0);
`endif
      tick();
      check("full.done_one_cycle", 32'(bus.done),     32'd0);
      check("full.playing_next",   32'(bus.playing),  32'd1);
      check("full.step_next",      32'(bus.step_idx), 32'd0);
      bus.run = 1'b0;

      // Reset asserted during the WAIT of step 7
      do_reset();
      write_pattern();
      bus.step_period = 26'd5;
      bus.run = 1'b1;
      for (int i = 0; i < 8; i++) wait_event(1'b0, 20, "rstmid.pulse", p1);
      check("rstmid.step_before", 32'(bus.step_idx), 32'd7);
      check("rstmid.freq_before", bus.freq,          32'd523);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rstmid.step",    32'(bus.step_idx),   32'd0);
      check("rstmid.freq",    bus.freq,            32'd0);
      check("rstmid.playing", 32'(bus.playing),    32'd0);
      check("rstmid.start",   32'(bus.note_start), 32'd0);
      check("rstmid.done",    32'(bus.done),       32'd0);
      bus.step_period = 26'd3;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.note_start === 1'b1) pulses++;
      end
      check("rstmid.cleared_pulses", 32'(pulses),      32'd0);
      check("rstmid.cleared_freq",   bus.freq,         32'd0);
      check("rstmid.replaying",      32'(bus.playing), 32'd1);
      bus.run = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
